// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: RV32I width codes,
// FSM state encoding and the captured-request record.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Captured addresses are held at full RV32 width; the RAM uses only the low ADDR_W bits.
   localparam int REQ_ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ACCESS,
      RESP
   } dmem_state_t;

   typedef struct packed {
      logic                  we;
      logic [REQ_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
      logic [2:0]            funct3;
   } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane handling: load extract/extend, store byte-enable and merge,
// plus misalignment / illegal-width detection.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic        err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val;
   logic [31:0] wdata_rep;
   logic [3:0]  lanes;

   assign byte_sel = 8'(word >> {addr, 3'b000});
   assign half_sel = addr[1] ? word[31:16] : word[15:0];

   // NOTE: every variable driven here gets a default before the case, so no path can infer a latch.
   always_comb begin
      load_val  = '0;
      lanes     = 4'b0000;
      wdata_rep = wdata;
      err       = 1'b0;
      case (funct3)
         F3_B: begin
            load_val  = {{24{byte_sel[7]}}, byte_sel};
            lanes     = 4'b0001 << addr;
            wdata_rep = {4{wdata[7:0]}};
         end
         F3_H: begin
            load_val  = {{16{half_sel[15]}}, half_sel};
            lanes     = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            err       = addr[0];
         end
         F3_W: begin
            load_val = word;
            lanes    = 4'b1111;
            err      = (addr != 2'b00);
         end
         F3_BU: begin
            load_val = {24'd0, byte_sel};
            err      = we;
         end
         F3_HU: begin
            load_val = {16'd0, half_sel};
            err      = we | addr[0];
         end
         default: err = 1'b1;
      endcase

      rdata = (we || err) ? 32'd0 : load_val;
      be    = (we && !err) ? lanes : 4'b0000;

      // Replicated store data lands on the enabled lanes; the rest keep the old word.
      wword = word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) wword[i*8 +: 8] = wdata_rep[i*8 +: 8];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the MEM stage: word RAM, fixed programmable
// latency, RV32I lane selection on loads and byte-enable merging on stores.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int          WORDS    = 2 ** (ADDR_W - 2);
   localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   dmem_state_t        state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               accept;
   dmem_req_t          req_q;

   logic [DATA_W-1:0]  mem [WORDS];
   logic [ADDR_W-3:0]  word_idx;
   logic [31:0]        word_rd;
   logic [31:0]        rdata_al;
   logic [31:0]        wword;
   logic [3:0]         be;
   logic               err_al;

   assign word_idx = req_q.addr[ADDR_W-1:2];
   assign word_rd  = mem[word_idx];

   if (ADDR_W < REQ_ADDR_W) begin : g_addr_pad
      logic addr_unused;
      assign addr_unused = ^req_q.addr[REQ_ADDR_W-1:ADDR_W];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = !reset;
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY > 1) begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ACCESS:  state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rsp_valid = (state_q == RESP);

   always_ff @(posedge clock) begin
      if (accept) begin
         req_q <= '{we: req_we, addr: REQ_ADDR_W'(req_addr), wdata: req_wdata, funct3: req_funct3};
      end
   end

   dmem_lane_align u_align (
      .we     (req_q.we),
      .funct3 (req_q.funct3),
      .addr   (req_q.addr[1:0]),
      .word   (word_rd),
      .wdata  (req_q.wdata),
      .rdata  (rdata_al),
      .be     (be),
      .wword  (wword),
      .err    (err_al)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state_q == ACCESS) begin
         rsp_rdata <= rdata_al;
         rsp_err   <= err_al;
      end
   end

   // NOTE: the RAM array has no reset branch; its contents survive reset and it maps onto plain RAM.
   always_ff @(posedge clock) begin
      if (state_q == ACCESS && |be && !reset) begin
         mem[word_idx] <= wword;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: two instances (LATENCY 2 and 4) share stimulus,
// with req_valid steered to the instance selected by sel.
module tb_dmem_responder;

   localparam logic [2:0] T_B  = 3'b000;
   localparam logic [2:0] T_H  = 3'b001;
   localparam logic [2:0] T_W  = 3'b010;
   localparam logic [2:0] T_BU = 3'b100;
   localparam logic [2:0] T_HU = 3'b101;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
      string       name;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset, req_valid, req_we, rsp_ready, sel;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;

   logic        vld_a, vld_b, rdy_a, rdy_b, rv_a, rv_b, er_a, er_b;
   logic [31:0] rd_a, rd_b;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   assign vld_a     = req_valid & ~sel;
   assign vld_b     = req_valid & sel;
   assign req_ready = sel ? rdy_b : rdy_a;
   assign rsp_valid = sel ? rv_b  : rv_a;
   assign rsp_rdata = sel ? rd_b  : rd_a;
   assign rsp_err   = sel ? er_b  : er_a;

   dmem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(2)) u_dut2 (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (vld_a),
      .req_ready  (rdy_a),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rv_a),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rd_a),
      .rsp_err    (er_a)
   );

   dmem_responder #(.ADDR_W(12), .DATA_W(32), .LATENCY(4)) u_dut4 (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (vld_b),
      .req_ready  (rdy_b),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rv_b),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rd_b),
      .rsp_err    (er_b)
   );

   function automatic vec_t mk(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic [31:0] exp_rdata,
                               input logic exp_err, input string name);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
      return v;
   endfunction

   // Issues one request to the selected instance, counts edges from accept to rsp_valid,
   // and completes the handshake unless hold is set. All waits are bounded.
   task automatic run_xact(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input bit hold,
                           output logic [31:0] rdata, output logic err, output int lat);
      int n;
      req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clock); #1; n++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 50) begin
         @(posedge clock); #1; lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      if (!hold) begin
         rsp_ready = 1'b1;
         @(posedge clock); #1;
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
      req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = T_W;
      repeat (2) @(posedge clock);
      #1;
      n_checks++;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_req_ready: got %b/%b want 0/0", rdy_a, rdy_b);
      end
      n_checks++;
      if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp_valid: got %b/%b want 0/0", rv_a, rv_b);
      end
      n_checks++;
      if (rd_a !== 32'd0 || er_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", rd_a, er_a);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_ready: got %b/%b want 1/1", rdy_a, rdy_b);
      end
   endtask

   task automatic test_store_load();
      vec_t tbl[$];
      logic [31:0] rd; logic er; int lat;
      sel = 1'b0;
      tbl.push_back(mk(1'b1, 12'h010, 32'hDEADBEEF, T_W, 32'h0,        1'b0, "sw_010"));
      tbl.push_back(mk(1'b0, 12'h010, 32'h0,        T_W, 32'hDEADBEEF, 1'b0, "lw_010"));
      foreach (tbl[i]) begin
         run_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, 1'b0, rd, er, lat);
         n_checks++;
         if (lat !== 2) begin n_fail++; $display("FAIL %s latency: got %0d want 2", tbl[i].name, lat); end
         n_checks++;
         if (rd !== tbl[i].exp_rdata) begin n_fail++; $display("FAIL %s rdata: got %h want %h", tbl[i].name, rd, tbl[i].exp_rdata); end
         n_checks++;
         if (er !== tbl[i].exp_err) begin n_fail++; $display("FAIL %s err: got %b want %b", tbl[i].name, er, tbl[i].exp_err); end
      end
   endtask

   task automatic test_lanes();
      vec_t tbl[$];
      logic [31:0] rd; logic er; int lat;
      sel = 1'b0;
      tbl.push_back(mk(1'b1, 12'h013, 32'h0000007F, T_B,  32'h0,        1'b0, "sb_013"));
      tbl.push_back(mk(1'b0, 12'h013, 32'h0,        T_B,  32'h0000007F, 1'b0, "lb_013"));
      tbl.push_back(mk(1'b0, 12'h012, 32'h0,        T_B,  32'hFFFFFFAD, 1'b0, "lb_012"));
      tbl.push_back(mk(1'b0, 12'h012, 32'h0,        T_BU, 32'h000000AD, 1'b0, "lbu_012"));
      tbl.push_back(mk(1'b0, 12'h011, 32'h0,        T_B,  32'hFFFFFFBE, 1'b0, "lb_011"));
      tbl.push_back(mk(1'b0, 12'h010, 32'h0,        T_W,  32'h7FADBEEF, 1'b0, "lw_010_merged"));
      tbl.push_back(mk(1'b0, 12'h010, 32'h0,        T_H,  32'hFFFFBEEF, 1'b0, "lh_010"));
      tbl.push_back(mk(1'b0, 12'h012, 32'h0,        T_HU, 32'h00007FAD, 1'b0, "lhu_012"));
      tbl.push_back(mk(1'b1, 12'h020, 32'h11223344, T_W,  32'h0,        1'b0, "sw_020"));
      tbl.push_back(mk(1'b1, 12'h022, 32'h5A5A8001, T_H,  32'h0,        1'b0, "sh_022"));
      tbl.push_back(mk(1'b0, 12'h022, 32'h0,        T_H,  32'hFFFF8001, 1'b0, "lh_022"));
      tbl.push_back(mk(1'b0, 12'h022, 32'h0,        T_HU, 32'h00008001, 1'b0, "lhu_022"));
      tbl.push_back(mk(1'b0, 12'h020, 32'h0,        T_HU, 32'h00003344, 1'b0, "lhu_020_kept"));
      tbl.push_back(mk(1'b0, 12'h020, 32'h0,        T_W,  32'h80013344, 1'b0, "lw_020"));
      foreach (tbl[i]) begin
         run_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, 1'b0, rd, er, lat);
         n_checks++;
         if (lat !== 2) begin n_fail++; $display("FAIL %s latency: got %0d want 2", tbl[i].name, lat); end
         n_checks++;
         if (rd !== tbl[i].exp_rdata) begin n_fail++; $display("FAIL %s rdata: got %h want %h", tbl[i].name, rd, tbl[i].exp_rdata); end
         n_checks++;
         if (er !== tbl[i].exp_err) begin n_fail++; $display("FAIL %s err: got %b want %b", tbl[i].name, er, tbl[i].exp_err); end
      end
   endtask

   task automatic test_errors();
      vec_t tbl[$];
      logic [31:0] rd; logic er; int lat;
      sel = 1'b0;
      tbl.push_back(mk(1'b0, 12'h011, 32'h0,        T_W,    32'h0,        1'b1, "lw_misaligned"));
      tbl.push_back(mk(1'b0, 12'h023, 32'h0,        T_H,    32'h0,        1'b1, "lh_misaligned"));
      tbl.push_back(mk(1'b1, 12'h021, 32'h0000FFFF, T_H,    32'h0,        1'b1, "sh_misaligned"));
      tbl.push_back(mk(1'b1, 12'h022, 32'hCCCCCCCC, T_W,    32'h0,        1'b1, "sw_misaligned"));
      tbl.push_back(mk(1'b0, 12'h020, 32'h0,        3'b011, 32'h0,        1'b1, "load_f3_011"));
      tbl.push_back(mk(1'b0, 12'h020, 32'h0,        3'b111, 32'h0,        1'b1, "load_f3_111"));
      tbl.push_back(mk(1'b1, 12'h020, 32'h000000FF, T_BU,   32'h0,        1'b1, "store_f3_100"));
      tbl.push_back(mk(1'b1, 12'h020, 32'h0000FFFF, T_HU,   32'h0,        1'b1, "store_f3_101"));
      tbl.push_back(mk(1'b1, 12'h010, 32'h000000AA, 3'b110, 32'h0,        1'b1, "store_f3_110"));
      tbl.push_back(mk(1'b0, 12'h020, 32'h0,        T_W,    32'h80013344, 1'b0, "lw_020_unchanged"));
      tbl.push_back(mk(1'b0, 12'h010, 32'h0,        T_W,    32'h7FADBEEF, 1'b0, "lw_010_unchanged"));
      foreach (tbl[i]) begin
         run_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, 1'b0, rd, er, lat);
         n_checks++;
         if (lat !== 2) begin n_fail++; $display("FAIL %s latency: got %0d want 2", tbl[i].name, lat); end
         n_checks++;
         if (rd !== tbl[i].exp_rdata) begin n_fail++; $display("FAIL %s rdata: got %h want %h", tbl[i].name, rd, tbl[i].exp_rdata); end
         n_checks++;
         if (er !== tbl[i].exp_err) begin n_fail++; $display("FAIL %s err: got %b want %b", tbl[i].name, er, tbl[i].exp_err); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat;
      sel = 1'b0;
      run_xact(1'b0, 12'h010, 32'h0, T_W, 1'b1, rd, er, lat);
      n_checks++;
      if (lat !== 2 || rd !== 32'h7FADBEEF) begin
         n_fail++; $display("FAIL hold_first: got lat %0d data %h want 2 7fadbeef", lat, rd);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clock); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h7FADBEEF || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: got valid %b data %h ready %b want 1 7fadbeef 0",
                     c, rsp_valid, rsp_rdata, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: got valid %b ready %b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] rd; logic er; int lat; int n; bit seen;
      sel = 1'b1;
      run_xact(1'b1, 12'h030, 32'hCAFEF00D, T_W, 1'b0, rd, er, lat);
      n_checks++;
      if (lat !== 4 || er !== 1'b0) begin
         n_fail++; $display("FAIL lat4_sw: got lat %0d err %b want 4 0", lat, er);
      end
      run_xact(1'b0, 12'h030, 32'h0, T_W, 1'b0, rd, er, lat);
      n_checks++;
      if (lat !== 4 || rd !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL lat4_lw: got lat %0d data %h want 4 cafef00d", lat, rd);
      end
      req_we = 1'b1; req_addr = 12'h030; req_wdata = 32'h12345678; req_funct3 = T_W;
      req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(posedge clock); #1; n++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (rsp_valid !== 1'b0) seen = 1'b1;
         @(posedge clock); #1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_rsp: got rsp_valid seen %b want 0", seen);
      end
      run_xact(1'b0, 12'h030, 32'h0, T_W, 1'b0, rd, er, lat);
      n_checks++;
      if (lat !== 4 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
         n_fail++; $display("FAIL abort_kept: got lat %0d data %h err %b want 4 cafef00d 0", lat, rd, er);
      end
      sel = 1'b0;
      run_xact(1'b0, 12'h020, 32'h0, T_W, 1'b0, rd, er, lat);
      n_checks++;
      if (lat !== 2 || rd !== 32'h80013344) begin
         n_fail++; $display("FAIL ram_survives_reset: got lat %0d data %h want 2 80013344", lat, rd);
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_lanes();
      test_errors();
      test_backpressure();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
